// File: rtl/qupls_rename_stage_pkg.sv
// Purpose : shared types and sizing for the register-rename stage.
// Latency : n/a (types, constants and one helper only).
// Backpr. : n/a.
package qupls_rename_stage_pkg;

    localparam int NAREG    = 128;
    localparam int NPREG    = 256;
    localparam int AREG_W   = 9;
    localparam int AIDX_W   = $clog2(NAREG);
    localparam int PREG_W   = $clog2(NPREG);
    // Free-list pointers carry one extra wrap bit so full and empty differ.
    localparam int FL_PTR_W = PREG_W + 1;
    localparam int FL_CAP   = NPREG - NAREG;

    typedef logic [AREG_W-1:0] aregno_t;
    typedef logic [PREG_W-1:0] pregno_t;

    typedef struct packed {
        pregno_t pRa;
        pregno_t pRb;
        pregno_t pRc;
        pregno_t pRt;
        pregno_t pRt_old;
        logic    Rt_we;
    } rename_out_t;

    // r0 is hard-wired to p0 and never receives a new mapping.
    function automatic logic is_rename_dst(aregno_t rt, logic we);
        return we && (rt != '0);
    endfunction

endpackage

// File: rtl/qupls_rename_stage_if.sv
// Purpose : decode-side input, ROB-side output, commit and flush signals of the rename stage.
// Latency : n/a (wiring only).
// Backpr. : in_ready/out_ready valid-ready pairs; commit and flush are unconditional.
// Modports: master = upstream/downstream environment, slave = rename stage.
interface qupls_rename_stage_if;
    import qupls_rename_stage_pkg::*;

    logic    in_valid;
    logic    in_ready;
    aregno_t in_Ra;
    aregno_t in_Rb;
    aregno_t in_Rc;
    aregno_t in_Rt;
    logic    in_Rt_we;

    logic    out_valid;
    logic    out_ready;
    pregno_t out_pRa;
    pregno_t out_pRb;
    pregno_t out_pRc;
    pregno_t out_pRt;
    pregno_t out_pRt_old;
    logic    out_Rt_we;

    logic    cmt_valid;
    aregno_t cmt_aRt;
    pregno_t cmt_pRt;
    pregno_t cmt_pRt_old;
    logic    flush;

    modport master (
        output in_valid, in_Ra, in_Rb, in_Rc, in_Rt, in_Rt_we,
        input  in_ready,
        input  out_valid, out_pRa, out_pRb, out_pRc, out_pRt, out_pRt_old, out_Rt_we,
        output out_ready,
        output cmt_valid, cmt_aRt, cmt_pRt, cmt_pRt_old, flush
    );

    modport slave (
        input  in_valid, in_Ra, in_Rb, in_Rc, in_Rt, in_Rt_we,
        output in_ready,
        output out_valid, out_pRa, out_pRb, out_pRc, out_pRt, out_pRt_old, out_Rt_we,
        input  out_ready,
        input  cmt_valid, cmt_aRt, cmt_pRt, cmt_pRt_old, flush
    );

endinterface

// File: rtl/qupls_rename_stage_freelist.sv
// Purpose : circular free list of physical registers, with speculative head, committed head and tail.
// Latency : allocation reads fifo[head] combinationally; a release is allocatable the following cycle.
// Backpr. : none internally; the caller must gate alloc_i with !empty_o.
// Ports   : clk/rst_n, alloc_i (pop), cmt_i + rel_preg_i (push and advance chead),
//           rollback_i (head <= committed head), head_preg_o, count_o, empty_o.
module qupls_rename_stage_freelist
    import qupls_rename_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alloc_i,
    input  logic                cmt_i,
    input  pregno_t             rel_preg_i,
    input  logic                rollback_i,
    output pregno_t             head_preg_o,
    output logic [FL_PTR_W-1:0] count_o,
    output logic                empty_o
);

    pregno_t             fifo_q [NPREG];
    logic [FL_PTR_W-1:0] head_q, head_d;
    logic [FL_PTR_W-1:0] chead_q, chead_d;
    logic [FL_PTR_W-1:0] tail_q, tail_d;

    always_comb begin
        chead_d = chead_q + FL_PTR_W'(cmt_i);
        tail_d  = tail_q + FL_PTR_W'(cmt_i);
        // Rollback lands on the committed head including this cycle's commit.
        head_d  = rollback_i ? chead_d : head_q + FL_PTR_W'(alloc_i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            chead_q <= '0;
            tail_q  <= FL_PTR_W'(FL_CAP);
        end else begin
            head_q  <= head_d;
            chead_q <= chead_d;
            tail_q  <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NPREG; i++) begin
                fifo_q[i] <= (i < FL_CAP) ? pregno_t'(NAREG + i) : '0;
            end
        end else if (cmt_i) begin
            fifo_q[tail_q[PREG_W-1:0]] <= rel_preg_i;
        end
    end

    assign head_preg_o = fifo_q[head_q[PREG_W-1:0]];
    assign count_o     = tail_q - head_q;
    assign empty_o     = (count_o == '0);

    // More free entries than non-architectural registers means a double release.
    assert property (@(posedge clk) disable iff (!rst_n) count_o <= FL_PTR_W'(FL_CAP));

endmodule

// File: rtl/qupls_rename_stage.sv
// Purpose : rename stage; maps Ra/Rb/Rc through the speculative RAT and allocates a new pRt.
// Latency : 1 cycle from accept to output register.
// Backpr. : in_ready low while output stalled, flush, or Rt allocation needed with empty free list.
// Ports   : clk, rst_n (sync, active low), bus (slave modport: in/out handshake, commit, flush).
module qupls_rename_stage
    import qupls_rename_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    qupls_rename_stage_if.slave    bus
);

    pregno_t spec_map_q      [NAREG];
    pregno_t committed_map_q [NAREG];

    rename_out_t out_q, out_d;
    logic        out_valid_q, out_valid_d;

    logic [AIDX_W-1:0]   ra_idx, rb_idx, rc_idx, rt_idx, cmt_idx;
    logic                in_ready, accept, do_alloc, do_cmt;
    pregno_t             fl_head_preg;
    logic [FL_PTR_W-1:0] fl_count;
    logic                fl_empty;
    logic                unused_bits;

    assign ra_idx  = bus.in_Ra[AIDX_W-1:0];
    assign rb_idx  = bus.in_Rb[AIDX_W-1:0];
    assign rc_idx  = bus.in_Rc[AIDX_W-1:0];
    assign rt_idx  = bus.in_Rt[AIDX_W-1:0];
    assign cmt_idx = bus.cmt_aRt[AIDX_W-1:0];

    // Source numbers are always < NAREG here, so their top bits carry nothing.
    assign unused_bits = ^{bus.in_Ra[AREG_W-1:AIDX_W], bus.in_Rb[AREG_W-1:AIDX_W],
                           bus.in_Rc[AREG_W-1:AIDX_W], fl_count};

    always_comb begin
        in_ready = !bus.flush
                && (!out_valid_q || bus.out_ready)
                && (!bus.in_Rt_we || (bus.in_Rt == '0) || !fl_empty);
        accept   = bus.in_valid && in_ready;
        do_alloc = accept && is_rename_dst(bus.in_Rt, bus.in_Rt_we);
        do_cmt   = bus.cmt_valid && (bus.cmt_aRt != '0);
    end

    qupls_rename_stage_freelist u_freelist (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_i     (do_alloc),
        .cmt_i       (do_cmt),
        .rel_preg_i  (bus.cmt_pRt_old),
        .rollback_i  (bus.flush),
        .head_preg_o (fl_head_preg),
        .count_o     (fl_count),
        .empty_o     (fl_empty)
    );

    // Map tables. Flush copies the committed table with this cycle's commit folded in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NAREG; i++) begin
                spec_map_q[i]      <= pregno_t'(i);
                committed_map_q[i] <= pregno_t'(i);
            end
        end else begin
            if (do_cmt) begin
                committed_map_q[cmt_idx] <= bus.cmt_pRt;
            end
            if (bus.flush) begin
                for (int i = 0; i < NAREG; i++) begin
                    spec_map_q[i] <= (do_cmt && (cmt_idx == AIDX_W'(i))) ? bus.cmt_pRt
                                                                          : committed_map_q[i];
                end
            end else if (do_alloc) begin
                spec_map_q[rt_idx] <= fl_head_preg;
            end
        end
    end

    // Output register; sources read pre-update so Ra == Rt sees the old mapping.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d   = 1'b1;
            out_d.pRa     = spec_map_q[ra_idx];
            out_d.pRb     = spec_map_q[rb_idx];
            out_d.pRc     = spec_map_q[rc_idx];
            out_d.pRt     = do_alloc ? fl_head_preg : '0;
            out_d.pRt_old = do_alloc ? spec_map_q[rt_idx] : '0;
            out_d.Rt_we   = bus.in_Rt_we;
        end else if (bus.flush || bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pRa     = out_q.pRa;
    assign bus.out_pRb     = out_q.pRb;
    assign bus.out_pRc     = out_q.pRc;
    assign bus.out_pRt     = out_q.pRt;
    assign bus.out_pRt_old = out_q.pRt_old;
    assign bus.out_Rt_we   = out_q.Rt_we;

endmodule

// File: tb/tb_qupls_rename_stage.sv
// Purpose : directed bench for the rename stage with a queue-based scoreboard.
// Latency : expects each accepted instruction on the output one cycle later.
// Backpr. : drives out_ready low to exercise output stalls.
module tb_qupls_rename_stage;
    import qupls_rename_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    qupls_rename_stage_if u_if ();

    qupls_rename_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    rename_out_t exp_q [$];
    rename_out_t mon_e;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every output handshake pops one expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && u_if.out_valid && u_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", int'(u_if.out_valid), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_pRa",     int'(u_if.out_pRa),     int'(mon_e.pRa));
                    check("out_pRb",     int'(u_if.out_pRb),     int'(mon_e.pRb));
                    check("out_pRc",     int'(u_if.out_pRc),     int'(mon_e.pRc));
                    check("out_pRt",     int'(u_if.out_pRt),     int'(mon_e.pRt));
                    check("out_pRt_old", int'(u_if.out_pRt_old), int'(mon_e.pRt_old));
                    check("out_Rt_we",   int'(u_if.out_Rt_we),   int'(mon_e.Rt_we));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        u_if.in_valid    = 1'b0;
        u_if.in_Ra       = '0;
        u_if.in_Rb       = '0;
        u_if.in_Rc       = '0;
        u_if.in_Rt       = '0;
        u_if.in_Rt_we    = 1'b0;
        u_if.out_ready   = 1'b1;
        u_if.cmt_valid   = 1'b0;
        u_if.cmt_aRt     = '0;
        u_if.cmt_pRt     = '0;
        u_if.cmt_pRt_old = '0;
        u_if.flush       = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        drive_idle();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid",   int'(u_if.out_valid),   0);
        check("rst_out_pRa",     int'(u_if.out_pRa),     0);
        check("rst_out_pRt",     int'(u_if.out_pRt),     0);
        check("rst_out_pRt_old", int'(u_if.out_pRt_old), 0);
        check("rst_in_ready",    int'(u_if.in_ready),    1);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Present one instruction, wait for acceptance, record its expected rename.
    task automatic send(int ra, int rb, int rc, int rt, int we,
                        int e_ra, int e_rb, int e_rc, int e_rt, int e_old);
        int waited;
        u_if.in_Ra    = aregno_t'(ra);
        u_if.in_Rb    = aregno_t'(rb);
        u_if.in_Rc    = aregno_t'(rc);
        u_if.in_Rt    = aregno_t'(rt);
        u_if.in_Rt_we = (we != 0);
        u_if.in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!u_if.in_ready && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (!u_if.in_ready) begin
            check("send_in_ready_timeout", int'(u_if.in_ready), 1);
        end else begin
            exp_q.push_back(rename_out_t'{pRa: pregno_t'(e_ra), pRb: pregno_t'(e_rb),
                                          pRc: pregno_t'(e_rc), pRt: pregno_t'(e_rt),
                                          pRt_old: pregno_t'(e_old), Rt_we: (we != 0)});
        end
        @(posedge clk);
        #1 u_if.in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        do_reset();

        // Basic mapping, RAW on renamed register, re-rename of the same Rt.
        send(3, 5, 9, 7, 1,   3, 5, 9, 128, 7);
        send(7, 0, 0, 0, 0,   128, 0, 0, 0, 0);
        send(0, 0, 0, 7, 1,   0, 0, 0, 129, 128);
        send(7, 7, 0, 7, 1,   129, 129, 0, 130, 129);
        drain();
        do_reset();

        // Rt = 0 never allocates.
        send(0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
        send(0, 0, 0, 12, 1,  0, 0, 0, 128, 12);
        drain();
        do_reset();

        // Exhaust the free list, then release one entry through commit.
        for (int i = 0; i < 128; i++) begin
            send(0, 0, 0, 1, 1, 0, 0, 0, 128 + i, (i == 0) ? 1 : 127 + i);
        end
        u_if.in_Rt    = aregno_t'(2);
        u_if.in_Rt_we = 1'b1;
        @(negedge clk);
        check("full_in_ready", int'(u_if.in_ready), 0);
        u_if.in_Rt_we = 1'b0;
        @(negedge clk);
        check("full_no_we_in_ready", int'(u_if.in_ready), 1);
        u_if.in_Rt_we = 1'b1;
        @(posedge clk);
        #1;
        u_if.cmt_valid   = 1'b1;
        u_if.cmt_aRt     = aregno_t'(1);
        u_if.cmt_pRt     = pregno_t'(128);
        u_if.cmt_pRt_old = pregno_t'(1);
        @(negedge clk);
        check("cmt_cycle_in_ready", int'(u_if.in_ready), 0);
        @(posedge clk);
        #1 u_if.cmt_valid = 1'b0;
        @(negedge clk);
        check("post_cmt_in_ready", int'(u_if.in_ready), 1);
        @(posedge clk);
        #1;
        send(0, 0, 0, 2, 1,   0, 0, 0, 1, 2);
        drain();
        do_reset();

        // Flush with a same-cycle commit of r4 while r5's rename is stalled on the output.
        send(0, 0, 0, 4, 1,   0, 0, 0, 128, 4);
        send(0, 0, 0, 5, 1,   0, 0, 0, 129, 5);
        u_if.out_ready   = 1'b0;
        u_if.cmt_valid   = 1'b1;
        u_if.cmt_aRt     = aregno_t'(4);
        u_if.cmt_pRt     = pregno_t'(128);
        u_if.cmt_pRt_old = pregno_t'(4);
        u_if.flush       = 1'b1;
        u_if.in_Rt_we    = 1'b0;
        @(negedge clk);
        check("flush_in_ready", int'(u_if.in_ready), 0);
        @(posedge clk);
        #1;
        u_if.cmt_valid = 1'b0;
        u_if.flush     = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("flush_out_valid", int'(u_if.out_valid), 0);
        @(posedge clk);
        #1 u_if.out_ready = 1'b1;
        send(5, 4, 0, 0, 0,   5, 128, 0, 0, 0);
        send(0, 0, 0, 6, 1,   0, 0, 0, 129, 6);
        drain();
        do_reset();

        // Output stall: held data, no acceptance, free-list head unchanged.
        u_if.out_ready = 1'b0;
        send(0, 0, 0, 10, 1,  0, 0, 0, 128, 10);
        u_if.in_Rt    = aregno_t'(11);
        u_if.in_Rt_we = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_in_ready",    int'(u_if.in_ready),    0);
            check("stall_out_valid",   int'(u_if.out_valid),   1);
            check("stall_out_pRt",     int'(u_if.out_pRt),     128);
            check("stall_out_pRt_old", int'(u_if.out_pRt_old), 10);
        end
        @(posedge clk);
        #1 u_if.out_ready = 1'b1;
        send(0, 0, 0, 11, 1,  0, 0, 0, 129, 11);
        send(11, 10, 0, 0, 0, 129, 128, 0, 0, 0);
        drain();

        // Reset while an output is stalled discards it and restores the initial state.
        u_if.out_ready = 1'b0;
        send(0, 0, 0, 12, 1,  0, 0, 0, 130, 12);
        do_reset();
        send(12, 0, 0, 12, 1, 12, 0, 0, 128, 12);
        drain();

        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/qupls_rename_stage.md
Name: qupls_rename_stage

Overview:
- Register-rename stage directly downstream of the architectural operand decoders (Ra/Rb/Rc/Rt).
- Accepts one decoded instruction per cycle carrying architectural register numbers; the per-mode stack-pointer remapping (63 -> 65+om) and regx extension are already applied upstream.
- Maps each operand through a speculative register alias table and allocates a fresh physical destination from a FIFO free list.
- Retires mappings via an in-order commit port; flush rolls the speculative state back to the committed state.

Parameters:
- NAREG, 128, architectural registers (indices 0..127 of aregno_t).
- NPREG, 256, physical registers; must be power of two and > NAREG.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage can accept this cycle.
- in_Ra, in_Rb, in_Rc, in_Rt  in  9 each (aregno_t)  architectural source/dest numbers.
- in_Rt_we  in  1  instruction writes Rt.
- out_valid  out  1  renamed instruction held in output register.
- out_ready  in  1  downstream accepts.
- out_pRa, out_pRb, out_pRc, out_pRt  out  $clog2(NPREG) each (pregno_t)  physical numbers.
- out_pRt_old  out  pregno_t  previous mapping of Rt, carried to the ROB for freeing at commit.
- out_Rt_we  out  1  registered copy of in_Rt_we.
- cmt_valid  in  1  in-order commit of one Rt-writing instruction.
- cmt_aRt  in  aregno_t  committed destination.
- cmt_pRt  in  pregno_t  committed new mapping.
- cmt_pRt_old  in  pregno_t  mapping being released.
- flush  in  1  discard all uncommitted renames.

Behaviour:
- Reset (rst_n low at clk edge):
  - spec_map[i] = committed_map[i] = i for all i < NAREG.
  - Free FIFO holds NAREG..NPREG-1 in ascending order: head = chead = 0, tail = NPREG-NAREG.
  - out_valid = 0; all out_* data = 0.
  - Reset mid-stream discards everything, including the output register.
- Pointers are $clog2(NPREG)+1 bits with a wrap bit; count = tail - head; empty when count == 0.
- in_ready = !flush && (!out_valid || out_ready) && (!in_Rt_we || in_Rt == 0 || count != 0).
- Accept (in_valid && in_ready) has 1-cycle latency to the output register:
  - Sources are read from spec_map before the same-edge update, so Ra == Rt yields the old mapping.
  - If in_Rt_we and in_Rt != 0: out_pRt = fifo[head], out_pRt_old = spec_map[in_Rt], spec_map[in_Rt] <= fifo[head], head++.
  - Otherwise: out_pRt = 0, out_pRt_old = 0, head unchanged.
  - Register 0 always maps to p0 and is never renamed or freed.
- Output: out_valid is set on accept. It clears when out_ready is high and there is no new accept. The output holds stable while out_valid && !out_ready.
- Commit (cmt_valid, cmt_aRt != 0):
  - committed_map[cmt_aRt] <= cmt_pRt.
  - fifo[tail] <= cmt_pRt_old, tail++.
  - chead++ (tracks in-order committed allocations).
  - cmt_valid with cmt_aRt == 0: no effect.
- Freed registers become allocatable the cycle after commit; there is no same-cycle bypass from commit to allocation.
- Flush (highest priority over accept; commit in the same cycle is applied first):
  - spec_map <= committed_map (including the same-cycle commit update).
  - head <= chead (+1 if a commit occurs that cycle).
  - out_valid <= 0; in_ready = 0 that cycle.
- Simultaneous accept + commit: head and tail both advance; count is unchanged.
- Invariant, checked by assertion: count <= NPREG-NAREG. A push when the FIFO is full is a bench error.

Decomposition:
- QuplsPkg additions: pregno_t typedef, NPREG/NAREG constants, rename_out_t struct bundling the out_* fields.
- One sub-module, qupls_rename_freelist: FIFO storage plus head/chead/tail pointers, alloc/release/rollback controls, count/empty outputs.
- Map tables (spec and committed) stay in the top module as flop arrays.

Test Plan:
- Reset, then accept Ra=3, Rb=5, Rt=7 (we) -> next cycle out_pRa=3, out_pRb=5, out_pRt=128, out_pRt_old=7.
- Follow with Ra=7 -> out_pRa=128. Then Rt=7 again (we) -> out_pRt=129, out_pRt_old=128.
- Rt=0 with we=1 -> out_pRt=0, head unchanged; next Rt-writing instruction still gets p128.
- 128 back-to-back Rt allocations without commit -> in_ready drops on the 129th.
  - Then cmt_valid with cmt_aRt=1, cmt_pRt=128, cmt_pRt_old=1 -> in_ready high next cycle, and the next allocation returns p1.
- Allocate r4->p128, r5->p129, commit r4 only, then flush:
  - Ra=5 returns p5, Ra=4 returns p128.
  - Next allocation returns p129; out_valid is 0 in the flush cycle.
- out_ready held low with out_valid=1 for 3 cycles -> output stable, in_ready=0, head unchanged. Release -> accepts resume with no lost or duplicated instruction.
